// File: rtl/mod_dbus_arbiter_pkg.sv
// Shared definitions for the data-bus arbiter and its helpers.
//   - DRW_* access-type encodings of the de/daddr/drw/din/dout bus
//   - arb_state_e: arbiter FSM state encodings (2 bits)
//   - sat_inc8: 8-bit saturating increment used by the hold counter
package mod_dbus_arbiter_pkg;

  localparam logic [1:0] DRW_NONE  = 2'b00;
  localparam logic [1:0] DRW_WRITE = 2'b01;
  localparam logic [1:0] DRW_READ  = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_OWN0 = 2'b01,
    ARB_OWN1 = 2'b10
  } arb_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mod_dbus_stall_timer.sv
// Counts consecutive stalled cycles of a bus transfer and pulses timeout
// on the cycle the count reaches TIMEOUT-1 while the stall persists.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   stall     - a transfer is in flight and the slave is stalling this cycle
//   timeout   - combinational pulse: this stalled cycle is the last allowed
// The count clears on any cycle without stall and after a timeout, so each
// transfer starts from zero.
module mod_dbus_stall_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic timeout
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] stall_cnt;

  assign timeout = stall && (stall_cnt == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (stall && !timeout) begin
      stall_cnt <= stall_cnt + 16'd1;
    end else begin
      stall_cnt <= 16'd0;
    end
  end

endmodule

// File: rtl/mod_dbus_arbiter.sv
// Two-master arbiter for one data-bus slave port (m0 = CPU data port,
// m1 = debug/bootloader master). Round-robin grant, bounded hold under
// contention, slave stall handshake with timeout/abort.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   mN_req/addr/drw/din           - master N request (held until mN_ack)
//   mN_dout, mN_ack               - read data and one-cycle completion pulse
//   s_de/daddr/drw/din, s_dout    - slave port
//   s_stall                       - slave not ready
//   err, err_master               - sticky timeout flag and offending master
//   dbg_state                     - current FSM state
// Handshake: a master raises req and holds addr/drw/din stable until it sees
// ack; a granted transfer completes in the first cycle with req=1 and
// s_stall=0 (or is aborted at timeout), ack and dout are valid in that
// same cycle, and the master drops or renews req on the next edge.
module mod_dbus_arbiter
  import mod_dbus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [1:0]  m0_drw,
  input  logic [31:0] m0_din,
  output logic [31:0] m0_dout,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [1:0]  m1_drw,
  input  logic [31:0] m1_din,
  output logic [31:0] m1_dout,
  output logic        m1_ack,
  output logic        s_de,
  output logic [31:0] s_daddr,
  output logic [1:0]  s_drw,
  output logic [31:0] s_din,
  input  logic [31:0] s_dout,
  input  logic        s_stall,
  output logic        err,
  output logic        err_master,
  output logic [1:0]  dbg_state
);

  arb_state_e  state, state_n;
  logic        last, last_n;
  logic [7:0]  hold_cnt, hold_n;
  logic        err_n, err_master_n;

  // Owner-side view of the bus, independent of which master owns it.
  logic        own_valid, own_sel, own_req, other_req;
  logic [31:0] own_addr, own_din;
  logic [1:0]  own_drw;
  logic        stall, timeout, done;
  logic [31:0] rdata;

  assign own_valid = (state == ARB_OWN0) || (state == ARB_OWN1);
  assign own_sel   = (state == ARB_OWN1);
  assign own_req   = own_sel ? m1_req  : m0_req;
  assign other_req = own_sel ? m0_req  : m1_req;
  assign own_addr  = own_sel ? m1_addr : m0_addr;
  assign own_drw   = own_sel ? m1_drw  : m0_drw;
  assign own_din   = own_sel ? m1_din  : m0_din;

  assign stall = own_valid && own_req && s_stall;
  assign done  = own_valid && own_req && (!s_stall || timeout);
  // An aborted transfer returns zero, as does any write.
  assign rdata = (!timeout && own_drw == DRW_READ) ? s_dout : 32'd0;
  assign dbg_state = state;

  mod_dbus_stall_timer #(.TIMEOUT(TIMEOUT)) u_stall_timer (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .timeout (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last       <= 1'b1;
      hold_cnt   <= 8'd0;
      err        <= 1'b0;
      err_master <= 1'b0;
    end else begin
      state      <= state_n;
      last       <= last_n;
      hold_cnt   <= hold_n;
      err        <= err_n;
      err_master <= err_master_n;
    end
  end

  always_comb begin
    state_n      = state;
    last_n       = last;
    hold_n       = hold_cnt;
    err_n        = err;
    err_master_n = err_master;
    s_de         = 1'b0;
    s_daddr      = 32'd0;
    s_drw        = DRW_NONE;
    s_din        = 32'd0;
    m0_ack       = 1'b0;
    m1_ack       = 1'b0;
    m0_dout      = 32'd0;
    m1_dout      = 32'd0;
    case (state)
      ARB_IDLE: begin
        hold_n = 8'd0;
        if (m0_req && m1_req) begin
          state_n = last ? ARB_OWN0 : ARB_OWN1;
        end else if (m0_req) begin
          state_n = ARB_OWN0;
        end else if (m1_req) begin
          state_n = ARB_OWN1;
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        s_de    = own_req;
        s_daddr = own_addr;
        s_drw   = own_drw;
        s_din   = own_din;
        if (done) begin
          if (own_sel) begin
            m1_ack  = 1'b1;
            m1_dout = rdata;
          end else begin
            m0_ack  = 1'b1;
            m0_dout = rdata;
          end
          last_n = own_sel;
          if (timeout) begin
            err_n        = 1'b1;
            err_master_n = own_sel;
          end
          // hold_cnt may sit above MAX_HOLD after an uncontended run, so
          // the handover test is >= rather than ==.
          if (other_req && (({1'b0, hold_cnt} + 9'd1) >= 9'(MAX_HOLD))) begin
            state_n = own_sel ? ARB_OWN0 : ARB_OWN1;
            hold_n  = 8'd0;
          end else begin
            hold_n  = sat_inc8(hold_cnt);
          end
        end else if (!own_req) begin
          // Withdrawn request (possibly mid-stall): no ack, bus moves on.
          state_n = other_req ? (own_sel ? ARB_OWN0 : ARB_OWN1) : ARB_IDLE;
          hold_n  = 8'd0;
        end
      end
      default: begin
        state_n = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mod_dbus_arbiter.sv
// Self-checking bench for mod_dbus_arbiter (MAX_HOLD = 2, TIMEOUT = 5).
// A transaction-level model of the arbiter is evaluated on every falling
// edge and compared against all DUT outputs; directed scenarios add literal
// expectations and a grant-order scoreboard.
module tb_mod_dbus_arbiter;
  import mod_dbus_arbiter_pkg::*;

  localparam int MAX_HOLD = 2;
  localparam int TIMEOUT  = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m0_din, m1_addr, m1_din;
  logic [1:0]  m0_drw, m1_drw;
  logic [31:0] m0_dout, m1_dout;
  logic        m0_ack, m1_ack;
  logic        s_de;
  logic [31:0] s_daddr, s_din, s_dout;
  logic [1:0]  s_drw;
  logic        s_stall;
  logic        err, err_master;
  logic [1:0]  dbg_state;

  mod_dbus_arbiter #(.MAX_HOLD(MAX_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_drw(m0_drw), .m0_din(m0_din),
    .m0_dout(m0_dout), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_drw(m1_drw), .m1_din(m1_din),
    .m1_dout(m1_dout), .m1_ack(m1_ack),
    .s_de(s_de), .s_daddr(s_daddr), .s_drw(s_drw), .s_din(s_din),
    .s_dout(s_dout), .s_stall(s_stall),
    .err(err), .err_master(err_master), .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: expected grant order ----------------
  logic [0:0] exp_q[$];
  logic       sb_on = 1'b0;

  // ---------------- behavioural model ----------------
  // own: -1 = bus free, 0/1 = owning master. streak = completed transfers in
  // a row by the owner; stalled = stalled cycles of the current transfer.
  int   own = -1;
  int   last_m = 1;
  int   streak = 0;
  int   stalled = 0;
  logic e_err = 1'b0;
  int   e_errm = 0;

  always @(negedge clk) begin : model_cmp
    logic        rq[2];
    logic [31:0] ad[2], dn[2];
    logic [1:0]  dw[2];
    logic        e_ack[2];
    logic [31:0] e_dout[2];
    logic        e_de;
    logic [31:0] e_addr, e_din;
    logic [1:0]  e_drw;
    logic        tmo;
    int          x, o;
    if (rst) begin
      own = -1; last_m = 1; streak = 0; stalled = 0; e_err = 1'b0; e_errm = 0;
    end else begin
      rq[0] = m0_req;  ad[0] = m0_addr; dw[0] = m0_drw; dn[0] = m0_din;
      rq[1] = m1_req;  ad[1] = m1_addr; dw[1] = m1_drw; dn[1] = m1_din;
      e_ack[0] = 1'b0; e_ack[1] = 1'b0; e_dout[0] = 32'd0; e_dout[1] = 32'd0;
      e_de = 1'b0; e_addr = 32'd0; e_drw = 2'b00; e_din = 32'd0;
      // Registered flags show the value from before this cycle's edge.
      chk("err", {31'd0, err}, {31'd0, e_err});
      chk("err_master", {31'd0, err_master}, 32'(e_errm));
      if (own < 0) begin
        if (rq[0] && rq[1]) own = (last_m == 1) ? 0 : 1;
        else if (rq[0])     own = 0;
        else if (rq[1])     own = 1;
        streak = 0; stalled = 0;
      end else begin
        x = own; o = 1 - x;
        e_de = rq[x]; e_addr = ad[x]; e_drw = dw[x]; e_din = dn[x];
        if (rq[x]) begin
          tmo = s_stall && (stalled + 1 == TIMEOUT);
          if (!s_stall || tmo) begin
            e_ack[x]  = 1'b1;
            e_dout[x] = (!tmo && dw[x] == 2'b10) ? s_dout : 32'd0;
            stalled = 0;
            last_m = x;
            if (tmo) begin e_err = 1'b1; e_errm = x; end
            streak = (streak < 255) ? streak + 1 : 255;
            if (rq[o] && streak >= MAX_HOLD) begin own = o; streak = 0; end
          end else begin
            stalled++;
          end
        end else begin
          own = rq[o] ? o : -1;
          streak = 0; stalled = 0;
        end
      end
      chk("s_de", {31'd0, s_de}, {31'd0, e_de});
      chk("s_daddr", s_daddr, e_addr);
      chk("s_drw", {30'd0, s_drw}, {30'd0, e_drw});
      chk("s_din", s_din, e_din);
      chk("m0_ack", {31'd0, m0_ack}, {31'd0, e_ack[0]});
      chk("m1_ack", {31'd0, m1_ack}, {31'd0, e_ack[1]});
      chk("m0_dout", m0_dout, e_dout[0]);
      chk("m1_dout", m1_dout, e_dout[1]);
      if (sb_on && (m0_ack || m1_ack)) begin
        if (exp_q.size() == 0) chk("grant_extra", 32'd1, 32'd0);
        else chk("grant_order", {31'd0, m1_ack}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic [31:0] a, input logic [1:0] rw, input logic [31:0] d);
    m0_req = req; m0_addr = a; m0_drw = rw; m0_din = d;
  endtask

  task automatic drive_m1(input logic req, input logic [31:0] a, input logic [1:0] rw, input logic [31:0] d);
    m1_req = req; m1_addr = a; m1_drw = rw; m1_din = d;
  endtask

  task automatic idle_bus(input int n);
    drive_m0(1'b0, 32'd0, DRW_NONE, 32'd0);
    drive_m1(1'b0, 32'd0, DRW_NONE, 32'd0);
    s_stall = 1'b0;
    repeat (n) tick();
  endtask

  // Watchdog: the directed sequence is bounded, this only guards a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1;
    drive_m0(1'b0, 32'd0, DRW_NONE, 32'd0);
    drive_m1(1'b0, 32'd0, DRW_NONE, 32'd0);
    s_dout = 32'd0; s_stall = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_s_de", {31'd0, s_de}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, ARB_IDLE});
    tick();
    rst = 1'b0;

    // Single read by m0.
    drive_m0(1'b1, 32'h0, DRW_READ, 32'd0);
    s_dout = 32'h0000_0203;
    @(negedge clk);
    chk("t1_arb_latency", {31'd0, s_de}, 32'd0);
    tick();
    @(negedge clk);
    chk("t1_s_de", {31'd0, s_de}, 32'd1);
    chk("t1_m0_ack", {31'd0, m0_ack}, 32'd1);
    chk("t1_m0_dout", m0_dout, 32'h0000_0203);
    chk("t1_m1_dout", m1_dout, 32'd0);
    tick();
    idle_bus(3);

    // Contention from reset with MAX_HOLD = 2: m0, m0, m1, m1, m0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    sb_on = 1'b1;
    drive_m0(1'b1, 32'h10, DRW_READ, 32'd0);
    drive_m1(1'b1, 32'h20, DRW_READ, 32'd0);
    s_dout = 32'h55;
    seen = 0;
    for (int i = 0; i < 20 && seen < 5; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) seen++;
    end
    chk("t2_ack_count", 32'(seen), 32'd5);
    tick();
    sb_on = 1'b0;
    chk("t2_queue_drained", 32'(exp_q.size()), 32'd0);
    idle_bus(3);

    // m1 write with 3 stall cycles.
    drive_m1(1'b1, 32'h4, DRW_WRITE, 32'hDEAD_BEEF);
    s_stall = 1'b1;
    @(negedge clk);
    chk("t3_idle_de", {31'd0, s_de}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) s_stall = 1'b0;
      @(negedge clk);
      chk("t3_s_din", s_din, 32'hDEAD_BEEF);
      chk("t3_s_daddr", s_daddr, 32'h4);
      chk("t3_m1_ack", {31'd0, m1_ack}, (i == 3) ? 32'd1 : 32'd0);
      chk("t3_err", {31'd0, err}, 32'd0);
    end
    tick();
    idle_bus(3);

    // Timeout (TIMEOUT = 5) on an m0 read, m1 waiting.
    drive_m0(1'b1, 32'h8, DRW_READ, 32'd0);
    drive_m1(1'b1, 32'hC, DRW_WRITE, 32'h1234_5678);
    s_stall = 1'b1;
    s_dout = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("t4_m0_ack", {31'd0, m0_ack}, (i == 4) ? 32'd1 : 32'd0);
      chk("t4_m0_dout", m0_dout, 32'd0);
    end
    tick();
    m0_req = 1'b0;
    @(negedge clk);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_err_master", {31'd0, err_master}, 32'd0);
    tick();
    @(negedge clk);
    chk("t4_m1_granted", {31'd0, s_de}, 32'd1);
    chk("t4_m1_addr", s_daddr, 32'hC);
    tick();
    s_stall = 1'b0;
    @(negedge clk);
    chk("t4_m1_ack", {31'd0, m1_ack}, 32'd1);
    tick();
    idle_bus(3);

    // m0 withdraws mid-stall while m1 requests.
    drive_m0(1'b1, 32'h18, DRW_READ, 32'd0);
    drive_m1(1'b1, 32'h1C, DRW_READ, 32'd0);
    s_stall = 1'b1;
    s_dout = 32'h0000_A5A5;
    repeat (3) tick();
    m0_req = 1'b0;
    @(negedge clk);
    chk("t5_no_m0_ack", {31'd0, m0_ack}, 32'd0);
    tick();
    @(negedge clk);
    chk("t5_state_own1", {30'd0, dbg_state}, {30'd0, ARB_OWN1});
    chk("t5_m1_addr", s_daddr, 32'h1C);
    tick();
    s_stall = 1'b0;
    @(negedge clk);
    chk("t5_m1_ack", {31'd0, m1_ack}, 32'd1);
    chk("t5_m1_dout", m1_dout, 32'h0000_A5A5);
    tick();
    idle_bus(3);

    // Asynchronous reset in the middle of an m1 stall.
    drive_m1(1'b1, 32'h30, DRW_READ, 32'd0);
    s_stall = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_s_de_async", {31'd0, s_de}, 32'd0);
    chk("t6_err_async", {31'd0, err}, 32'd0);
    chk("t6_m1_ack_async", {31'd0, m1_ack}, 32'd0);
    drive_m0(1'b1, 32'h40, DRW_READ, 32'd0);
    s_stall = 1'b0;
    s_dout = 32'h77;
    @(negedge clk);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_tie_to_m0", s_daddr, 32'h40);
    chk("t6_m0_ack", {31'd0, m0_ack}, 32'd1);
    chk("t6_m0_dout", m0_dout, 32'h77);
    tick();
    idle_bus(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
